// File: rtl/data_consumer_64_if.sv
// AXI4-Stream bundle carrying the host-to-card DMA data into data_consumer_64.
// The master drives data/keep/valid/last and the slave returns ready.
interface data_consumer_64_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/data_consumer_64.sv
// H2C stream consumer: checks {TAG, index} framing, buffers words and releases GRP_WORDS per new_sample.
// Optional tkeep checking is built in when DATA_CONSUMER_TKEEP_CHECK_EN is defined.
module data_consumer_64 #(
    parameter int                            DATA_WIDTH = 64,
    parameter int                            KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int                            IDX_W      = 28,
    parameter logic [DATA_WIDTH-IDX_W-1:0]   TAG        = 36'h0_000A_0000,
    parameter int                            PKT_WORDS  = 16384,
    parameter int                            GRP_WORDS  = 16,
    parameter int                            FIFO_AW    = 5
) (
    input  logic                  data_clk,
    input  logic                  user_rstn,
    input  logic                  dma_ena_i,
    input  logic                  new_sample_i,
    data_consumer_64_if.slave     s_axis,
    output logic [DATA_WIDTH-1:0] dac_data_o,
    output logic                  dac_valid_o,
    output logic                  err_seq_o,
    output logic                  err_last_o,
    output logic                  err_keep_o,
    output logic [15:0]           underrun_cnt_o,
    output logic [31:0]           pkt_cnt_o
);

    localparam int                GW       = $clog2(GRP_WORDS + 1);
    localparam int                DEPTH    = 1 << FIFO_AW;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PKT_WORDS - 1);
    localparam logic [GW-1:0]     GRP_LAST = GW'(GRP_WORDS - 1);
    localparam logic [FIFO_AW:0]  DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]  GRP_C    = (FIFO_AW + 1)'(GRP_WORDS);

    typedef enum logic [1:0] {
        IN_IDLE  = 2'd0,
        IN_RUN   = 2'd1,
        IN_DRAIN = 2'd2
    } in_state_e;

    typedef enum logic {
        OUT_WAIT = 1'b0,
        OUT_EMIT = 1'b1
    } out_state_e;

    in_state_e             in_state_q,  in_state_d;
    out_state_e            out_state_q, out_state_d;
    logic [IDX_W-1:0]      word_idx_q,  word_idx_d;
    logic [GW-1:0]         grp_idx_q,   grp_idx_d;
    logic                  err_seq_q,   err_seq_d;
    logic                  err_last_q,  err_last_d;
    logic                  err_keep_q,  err_keep_d;
    logic [15:0]           underrun_q,  underrun_d;
    logic [31:0]           pkt_cnt_q,   pkt_cnt_d;
    logic                  dma_ena_q;
    logic [DATA_WIDTH-1:0] dac_data_q;
    logic                  dac_valid_q;

    logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
    logic [FIFO_AW:0]      wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]      fifo_cnt_s;
    logic                  fifo_full_s;
    logic                  fifo_wr_s;
    logic                  fifo_pop_s;
    logic                  xfer_s;
    logic                  dma_rise_s;
    logic                  seq_bad_s;
    logic                  keep_bad_s;
    logic                  at_last_s;

    assign fifo_cnt_s    = wr_ptr_q - rd_ptr_q;
    assign fifo_full_s   = (fifo_cnt_s == DEPTH_C);
    assign s_axis.tready = ((in_state_q == IN_RUN) && !fifo_full_s) || (in_state_q == IN_DRAIN);
    assign xfer_s        = s_axis.tvalid && s_axis.tready;
    assign dma_rise_s    = dma_ena_i && !dma_ena_q;
    assign at_last_s     = (word_idx_q == LAST_IDX);
    assign seq_bad_s     = (s_axis.tdata[DATA_WIDTH-1:IDX_W] != TAG) ||
                           (s_axis.tdata[IDX_W-1:0] != word_idx_q);

`ifdef DATA_CONSUMER_TKEEP_CHECK_EN
    assign keep_bad_s = (s_axis.tkeep != {KEEP_WIDTH{1'b1}});
`else
    // err_keep can never be set, so tkeep is deliberately left unobserved.
    logic [KEEP_WIDTH-1:0] unused_keep_s;
    assign unused_keep_s = s_axis.tkeep;
    assign keep_bad_s    = 1'b0;
`endif

    // Input SM: framing/sequence checks, FIFO write enable and status counters.
    always_comb begin
        in_state_d = in_state_q;
        word_idx_d = word_idx_q;
        err_seq_d  = err_seq_q;
        err_last_d = err_last_q;
        err_keep_d = err_keep_q;
        pkt_cnt_d  = pkt_cnt_q;
        fifo_wr_s  = 1'b0;
        if (!dma_ena_i) begin
            in_state_d = IN_IDLE;
            word_idx_d = {IDX_W{1'b0}};
        end else if (dma_rise_s) begin
            in_state_d = IN_RUN;
            word_idx_d = {IDX_W{1'b0}};
            err_seq_d  = 1'b0;
            err_last_d = 1'b0;
            err_keep_d = 1'b0;
            pkt_cnt_d  = 32'd0;
        end else begin
            case (in_state_q)
                IN_IDLE: begin
                    in_state_d = IN_RUN;
                    word_idx_d = {IDX_W{1'b0}};
                end
                IN_RUN: begin
                    if (xfer_s) begin
                        fifo_wr_s  = 1'b1;
                        err_seq_d  = err_seq_q | seq_bad_s;
                        err_keep_d = err_keep_q | keep_bad_s;
                        if (s_axis.tlast) begin
                            word_idx_d = {IDX_W{1'b0}};
                            if (at_last_s) begin
                                pkt_cnt_d = pkt_cnt_q + 32'd1;
                            end else begin
                                err_last_d = 1'b1;
                            end
                        end else if (at_last_s) begin
                            // Missing tlast: discard until the sender closes its packet.
                            err_last_d = 1'b1;
                            in_state_d = IN_DRAIN;
                        end else begin
                            word_idx_d = word_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        in_state_d = IN_RUN;
                    end
                end
                IN_DRAIN: begin
                    if (xfer_s && s_axis.tlast) begin
                        in_state_d = IN_RUN;
                        word_idx_d = {IDX_W{1'b0}};
                    end else begin
                        in_state_d = IN_DRAIN;
                    end
                end
                default: begin
                    in_state_d = IN_IDLE;
                    word_idx_d = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Output SM: group release on new_sample and underrun accounting.
    always_comb begin
        out_state_d = out_state_q;
        grp_idx_d   = grp_idx_q;
        underrun_d  = underrun_q;
        fifo_pop_s  = 1'b0;
        if (!dma_ena_i) begin
            out_state_d = OUT_WAIT;
            grp_idx_d   = {GW{1'b0}};
        end else if (dma_rise_s) begin
            out_state_d = OUT_WAIT;
            grp_idx_d   = {GW{1'b0}};
            underrun_d  = 16'd0;
        end else begin
            case (out_state_q)
                OUT_WAIT: begin
                    if (new_sample_i && (fifo_cnt_s >= GRP_C)) begin
                        out_state_d = OUT_EMIT;
                        grp_idx_d   = {GW{1'b0}};
                    end else if (new_sample_i && (underrun_q != 16'hFFFF)) begin
                        underrun_d = underrun_q + 16'd1;
                    end else begin
                        out_state_d = OUT_WAIT;
                    end
                end
                OUT_EMIT: begin
                    fifo_pop_s = 1'b1;
                    // A strobe during a burst is never queued; it counts as starved.
                    if (new_sample_i && (underrun_q != 16'hFFFF)) begin
                        underrun_d = underrun_q + 16'd1;
                    end else begin
                        underrun_d = underrun_q;
                    end
                    if (grp_idx_q == GRP_LAST) begin
                        out_state_d = OUT_WAIT;
                        grp_idx_d   = {GW{1'b0}};
                    end else begin
                        grp_idx_d = grp_idx_q + {{(GW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    out_state_d = OUT_WAIT;
                    grp_idx_d   = {GW{1'b0}};
                end
            endcase
        end
    end

    // State and status registers.
    always_ff @(posedge data_clk or negedge user_rstn) begin
        if (!user_rstn) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_WAIT;
            word_idx_q  <= {IDX_W{1'b0}};
            grp_idx_q   <= {GW{1'b0}};
            err_seq_q   <= 1'b0;
            err_last_q  <= 1'b0;
            err_keep_q  <= 1'b0;
            underrun_q  <= 16'd0;
            pkt_cnt_q   <= 32'd0;
            dma_ena_q   <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            word_idx_q  <= word_idx_d;
            grp_idx_q   <= grp_idx_d;
            err_seq_q   <= err_seq_d;
            err_last_q  <= err_last_d;
            err_keep_q  <= err_keep_d;
            underrun_q  <= underrun_d;
            pkt_cnt_q   <= pkt_cnt_d;
            dma_ena_q   <= dma_ena_i;
        end
    end

    // FIFO pointers; dropping dma_ena empties the buffer.
    always_ff @(posedge data_clk or negedge user_rstn) begin
        if (!user_rstn) begin
            wr_ptr_q <= {(FIFO_AW+1){1'b0}};
            rd_ptr_q <= {(FIFO_AW+1){1'b0}};
        end else if (!dma_ena_i) begin
            wr_ptr_q <= {(FIFO_AW+1){1'b0}};
            rd_ptr_q <= {(FIFO_AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_q + {{FIFO_AW{1'b0}}, fifo_wr_s};
            rd_ptr_q <= rd_ptr_q + {{FIFO_AW{1'b0}}, fifo_pop_s};
        end
    end

    // FIFO storage.
    always_ff @(posedge data_clk) begin
        if (fifo_wr_s) begin
            fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= s_axis.tdata;
        end
    end

    // Registered DAC output, one cycle behind the pop.
    always_ff @(posedge data_clk or negedge user_rstn) begin
        if (!user_rstn) begin
            dac_data_q  <= {DATA_WIDTH{1'b0}};
            dac_valid_q <= 1'b0;
        end else if (!dma_ena_i) begin
            dac_valid_q <= 1'b0;
        end else begin
            dac_valid_q <= fifo_pop_s;
            if (fifo_pop_s) begin
                dac_data_q <= fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
            end
        end
    end

    assign dac_data_o     = dac_data_q;
    assign dac_valid_o    = dac_valid_q;
    assign err_seq_o      = err_seq_q;
    assign err_last_o     = err_last_q;
    assign err_keep_o     = err_keep_q;
    assign underrun_cnt_o = underrun_q;
    assign pkt_cnt_o      = pkt_cnt_q;

endmodule

// File: tb/tb_data_consumer_64.sv
// Scoreboard bench for data_consumer_64 with a 32-word packet and 16-word groups.
module tb_data_consumer_64;

    localparam logic [35:0] TAG = 36'h0_000A_0000;

    logic        data_clk;
    logic        user_rstn;
    logic        dma_ena;
    logic        new_sample;
    logic [63:0] dac_data;
    logic        dac_valid;
    logic        err_seq;
    logic        err_last;
    logic        err_keep;
    logic [15:0] underrun_cnt;
    logic [31:0] pkt_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] q_fifo [$];
    logic [63:0] q_exp  [$];

    data_consumer_64_if #(.DATA_WIDTH(64)) axis_if ();

    data_consumer_64 #(.PKT_WORDS(32), .GRP_WORDS(16), .FIFO_AW(5)) dut (
        .data_clk       (data_clk),
        .user_rstn      (user_rstn),
        .dma_ena_i      (dma_ena),
        .new_sample_i   (new_sample),
        .s_axis         (axis_if),
        .dac_data_o     (dac_data),
        .dac_valid_o    (dac_valid),
        .err_seq_o      (err_seq),
        .err_last_o     (err_last),
        .err_keep_o     (err_keep),
        .underrun_cnt_o (underrun_cnt),
        .pkt_cnt_o      (pkt_cnt)
    );

    initial data_clk = 1'b0;
    always #12 data_clk = ~data_clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [63:0] word(input int idx);
        return {TAG, 28'(idx)};
    endfunction

    // Monitor: every emitted word must match the next expected entry.
    always @(negedge data_clk) begin
        if (dac_valid === 1'b1) begin
            if (q_exp.size() == 0) begin
                total_cnt++;
                $display("FAIL dac_unexpected: got %0h expected no output", dac_data);
            end else begin
                check("dac_data", dac_data, q_exp.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge data_clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [63:0] d, input bit last, input bit to_fifo);
        bit rdy;
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        axis_if.tvalid = 1'b1;
        axis_if.tdata  = d;
        axis_if.tlast  = last;
        while (!done && n < 200) begin
            @(negedge data_clk);
            rdy = axis_if.tready;
            @(posedge data_clk);
            #1;
            if (rdy) done = 1'b1;
            else n++;
        end
        if (!done) begin
            total_cnt++;
            $display("FAIL tready_timeout: got no handshake expected one for %0h", d);
        end else if (to_fifo) begin
            q_fifo.push_back(d);
        end
    endtask

    task automatic send_words(input int from, input int to, input int last_at,
                              input int bad_pos, input logic [63:0] bad_val, input bit to_fifo);
        for (int i = from; i <= to; i++) begin
            send_word((i == bad_pos) ? bad_val : word(i), (i == last_at), to_fifo);
        end
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
    endtask

    // One strobe; a group is expected only if the bench's own FIFO image holds 16 words.
    task automatic strobe();
        bit emit;
        int first;
        int last;
        int nv;
        emit = (q_fifo.size() >= 16) && dma_ena;
        if (emit) begin
            repeat (16) q_exp.push_back(q_fifo.pop_front());
        end
        new_sample = 1'b1;
        @(posedge data_clk);
        #1;
        new_sample = 1'b0;
        first = 0;
        last = 0;
        nv = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge data_clk);
            if (dac_valid === 1'b1) begin
                nv++;
                if (first == 0) first = k;
                last = k;
            end
        end
        @(posedge data_clk);
        #1;
        if (emit) begin
            check("grp_first_valid", 64'(first), 64'd2);
            check("grp_valid_count", 64'(nv), 64'd16);
            check("grp_last_valid", 64'(last), 64'd17);
        end else begin
            check("starved_valid_count", 64'(nv), 64'd0);
        end
    endtask

    task automatic set_dma(input bit v);
        dma_ena = v;
        step(1);
        if (!v) q_fifo.delete();
    endtask

    initial begin
        user_rstn      = 1'b0;
        dma_ena        = 1'b0;
        new_sample     = 1'b0;
        axis_if.tdata  = 64'd0;
        axis_if.tkeep  = 8'hFF;
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
        step(3);
        check("rst_tready", 64'(axis_if.tready), 64'd0);
        check("rst_dac_valid", 64'(dac_valid), 64'd0);
        check("rst_dac_data", dac_data, 64'd0);
        check("rst_err_seq", 64'(err_seq), 64'd0);
        check("rst_err_last", 64'(err_last), 64'd0);
        check("rst_err_keep", 64'(err_keep), 64'd0);
        check("rst_underrun", 64'(underrun_cnt), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        user_rstn = 1'b1;
        step(2);

        // Clean packet fills the 32-deep FIFO exactly.
        set_dma(1'b1);
        send_words(0, 31, 31, -1, 64'd0, 1'b1);
        check("full_tready", 64'(axis_if.tready), 64'd0);
        check("p1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("p1_err_seq", 64'(err_seq), 64'd0);
        check("p1_err_last", 64'(err_last), 64'd0);
        check("p1_err_keep", 64'(err_keep), 64'd0);
        strobe();
        strobe();
        check("p1_underrun", 64'(underrun_cnt), 64'd0);
        check("empty_tready", 64'(axis_if.tready), 64'd1);

        // Word 5 carries index 7.
        send_words(0, 31, 31, 5, word(7), 1'b1);
        check("bad_idx_err_seq", 64'(err_seq), 64'd1);
        check("bad_idx_pkt_cnt", 64'(pkt_cnt), 64'd2);
        strobe();
        strobe();

        // Early tlast on index 10, then a correct packet.
        send_words(0, 10, 10, -1, 64'd0, 1'b1);
        check("early_err_last", 64'(err_last), 64'd1);
        check("early_pkt_cnt", 64'(pkt_cnt), 64'd2);
        send_words(0, 4, -1, -1, 64'd0, 1'b1);
        strobe();
        send_words(5, 31, 31, -1, 64'd0, 1'b1);
        check("after_early_pkt_cnt", 64'(pkt_cnt), 64'd3);
        strobe();

        // Drop and re-raise enable: hold while low, clear on the rising edge.
        set_dma(1'b0);
        check("off_tready", 64'(axis_if.tready), 64'd0);
        check("off_err_seq", 64'(err_seq), 64'd1);
        check("off_pkt_cnt", 64'(pkt_cnt), 64'd3);
        set_dma(1'b1);
        check("on_err_seq", 64'(err_seq), 64'd0);
        check("on_err_last", 64'(err_last), 64'd0);
        check("on_pkt_cnt", 64'(pkt_cnt), 64'd0);

        // Missing tlast on 31: drain 32..40 even with the FIFO full.
        send_words(0, 31, -1, -1, 64'd0, 1'b1);
        check("miss_err_last", 64'(err_last), 64'd1);
        check("drain_tready", 64'(axis_if.tready), 64'd1);
        send_words(32, 40, 40, -1, 64'd0, 1'b0);
        check("post_drain_tready", 64'(axis_if.tready), 64'd0);
        check("miss_pkt_cnt", 64'(pkt_cnt), 64'd0);
        strobe();
        strobe();
        send_words(0, 31, 31, -1, 64'd0, 1'b1);
        check("recover_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("recover_err_seq", 64'(err_seq), 64'd0);
        strobe();
        strobe();

        // Starved strobe with 3 words, then disable mid-packet.
        send_words(0, 2, -1, -1, 64'd0, 1'b1);
        strobe();
        check("starve_underrun", 64'(underrun_cnt), 64'd1);
        set_dma(1'b0);
        check("mid_off_tready", 64'(axis_if.tready), 64'd0);
        check("mid_off_dac_valid", 64'(dac_valid), 64'd0);
        check("mid_off_err_last", 64'(err_last), 64'd1);
        strobe();
        check("mid_off_underrun", 64'(underrun_cnt), 64'd1);
        check("mid_off_pkt_cnt", 64'(pkt_cnt), 64'd1);
        set_dma(1'b1);
        check("reon_underrun", 64'(underrun_cnt), 64'd0);
        check("reon_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("reon_err_last", 64'(err_last), 64'd0);
        send_words(0, 15, -1, -1, 64'd0, 1'b1);
        check("reon_err_seq", 64'(err_seq), 64'd0);
        strobe();

        step(4);
        check("scoreboard_drained", 64'(q_exp.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
